// File: rtl/map_port_arbiter.sv
// Round-robin arbiter sharing the tile-map write/read port between pac-man and ghost movers.
// One transaction in flight; READ, WRITE and WRITE_IF_FREE (read, then write unless the tile is a wall).
module map_port_arbiter #(
    parameter int unsigned N_REQ     = 5,
    parameter int unsigned AW        = 11,
    parameter int unsigned DW        = 4,
    parameter int unsigned MAP_SIZE  = 1200,
    parameter int unsigned WALL_CODE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic [N_REQ-1:0]      req,
    input  logic [2*N_REQ-1:0]    op,
    input  logic [AW*N_REQ-1:0]   addr,
    input  logic [DW*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]      ack,
    output logic [DW-1:0]         rsp_data,
    output logic                  rsp_ok,
    output logic                  busy,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_we,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CASW,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_WIF   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    state_e            r_state, w_state_next;
    op_e               r_op, w_op_next;
    logic [AW-1:0]     r_addr, w_addr_next;
    logic [DW-1:0]     r_wdata, w_wdata_next;
    logic [IW-1:0]     r_win, w_win_next;
    logic [IW-1:0]     r_ptr, w_ptr_next;
    logic [N_REQ-1:0]  r_ack, w_ack_next;
    logic [DW-1:0]     r_rsp_data, w_rsp_data_next;
    logic              r_rsp_ok, w_rsp_ok_next;
    logic              r_busy, w_busy_next;
    logic [AW-1:0]     r_mem_addr, w_mem_addr_next;
    logic              r_mem_we, w_mem_we_next;
    logic [DW-1:0]     r_mem_wdata, w_mem_wdata_next;

    logic              w_found;
    logic [IW-1:0]     w_grant;
    logic [IW-1:0]     w_cand;
    op_e               w_sel_op;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic              w_sel_bad;

    // Round-robin search starting at the pointer, first set req wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_cand = IW'((int'(r_ptr) + k) % int'(N_REQ));
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    assign w_sel_op    = op_e'(op[2*w_grant +: 2]);
    assign w_sel_addr  = addr[AW*w_grant +: AW];
    assign w_sel_wdata = wdata[DW*w_grant +: DW];
    assign w_sel_bad   = (w_sel_addr >= AW'(MAP_SIZE)) || (w_sel_op == OP_RSVD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_READ;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_win       <= '0;
            r_ptr       <= '0;
            r_ack       <= '0;
            r_rsp_data  <= '0;
            r_rsp_ok    <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_op        <= w_op_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_win       <= w_win_next;
            r_ptr       <= w_ptr_next;
            r_ack       <= w_ack_next;
            r_rsp_data  <= w_rsp_data_next;
            r_rsp_ok    <= w_rsp_ok_next;
            r_busy      <= w_busy_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_wdata <= w_mem_wdata_next;
        end
    end

    // Next-state and next registered outputs; ack/mem_we are set one state early so they land in RESP/ISSUE/CASW.
    always_comb begin
        w_state_next     = r_state;
        w_op_next        = r_op;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_win_next       = r_win;
        w_ptr_next       = r_ptr;
        w_ack_next       = '0;
        w_rsp_data_next  = r_rsp_data;
        w_rsp_ok_next    = r_rsp_ok;
        w_mem_addr_next  = r_mem_addr;
        w_mem_we_next    = 1'b0;
        w_mem_wdata_next = r_mem_wdata;

        unique case (r_state)
            ST_IDLE: begin
                if (!hold && w_found) begin
                    w_op_next    = w_sel_op;
                    w_addr_next  = w_sel_addr;
                    w_wdata_next = w_sel_wdata;
                    w_win_next   = w_grant;
                    w_ptr_next   = (w_grant == IW'(N_REQ - 1)) ? '0 : w_grant + IW'(1);
                    if (w_sel_bad) begin
                        w_state_next        = ST_RESP;
                        w_ack_next[w_grant] = 1'b1;
                        w_rsp_ok_next       = 1'b0;
                        w_rsp_data_next     = '0;
                    end else begin
                        w_state_next    = ST_ISSUE;
                        w_mem_addr_next = w_sel_addr;
                        if (w_sel_op == OP_WRITE) begin
                            w_mem_we_next    = 1'b1;
                            w_mem_wdata_next = w_sel_wdata;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (r_op == OP_WRITE) begin
                    w_state_next      = ST_RESP;
                    w_ack_next[r_win] = 1'b1;
                    w_rsp_ok_next     = 1'b1;
                    w_rsp_data_next   = '0;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_rsp_data_next = mem_rdata;
                if (r_op == OP_READ) begin
                    w_state_next      = ST_RESP;
                    w_ack_next[r_win] = 1'b1;
                    w_rsp_ok_next     = 1'b1;
                end else if (mem_rdata == DW'(WALL_CODE)) begin
                    w_state_next      = ST_RESP;
                    w_ack_next[r_win] = 1'b1;
                    w_rsp_ok_next     = 1'b0;
                end else begin
                    w_state_next     = ST_CASW;
                    w_mem_addr_next  = r_addr;
                    w_mem_we_next    = 1'b1;
                    w_mem_wdata_next = r_wdata;
                end
            end
            ST_CASW: begin
                w_state_next      = ST_RESP;
                w_ack_next[r_win] = 1'b1;
                w_rsp_ok_next     = 1'b1;
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    // Reset rising mid-transaction must suppress an ack or write already registered for this cycle.
    assign ack       = r_ack & {N_REQ{~reset}};
    assign mem_we    = r_mem_we & ~reset;
    assign rsp_data  = r_rsp_data;
    assign rsp_ok    = r_rsp_ok;
    assign busy      = r_busy;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter: registered map model, latency, ordering, write-if-free,
// invalid requests, hold, mid-transaction reset and round-robin fairness.
module tb_map_port_arbiter;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_WIF = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic [4:0]  req;
    logic [9:0]  op;
    logic [54:0] addr;
    logic [19:0] wdata;
    logic [4:0]  ack;
    logic [3:0]  rsp_data;
    logic        rsp_ok;
    logic        busy;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;

    logic [3:0]  mem [0:1199];
    int          wq_addr[$];
    int          wq_data[$];
    int          n_total = 0;
    int          n_bad   = 0;

    map_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rsp_data  (rsp_data),
        .rsp_ok    (rsp_ok),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Tile map with a registered read port; writes are also logged for checking.
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr < 11'd1200) mem[mem_addr] <= mem_wdata;
            wq_addr.push_back(int'(mem_addr));
            wq_data.push_back(int'(mem_wdata));
        end
        mem_rdata <= (mem_addr < 11'd1200) ? mem[mem_addr] : 4'd0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack != 5'd0) chk("ack_onehot", 32'($countones(ack)), 32'd1);
    end

    task automatic set_req(input int i, input logic [1:0] o, input int a, input int d);
        op[2*i +: 2]    = o;
        addr[11*i +: 11] = 11'(a);
        wdata[4*i +: 4] = 4'(d);
    endtask

    // Cycles are counted from the IDLE cycle that samples req; returns idx=-1 on timeout.
    task automatic wait_any(input int max_cyc, output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack != 5'd0) begin
                for (int b = 0; b < 5; b++) if (ack[b]) idx = b;
                cyc = c;
                return;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold  = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic finish_txn();
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        int idx, cyc, nack, nbusy;
        for (int a = 0; a < 1200; a++) mem[a] <= 4'd0;
        mem[817] <= 4'd4;
        mem[300] <= 4'd1;
        mem[301] <= 4'd2;
        op = '0; addr = '0; wdata = '0;

        // Reset values
        do_reset();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_ok", 32'(rsp_ok), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);

        // READ from pac-man
        wq_addr.delete(); wq_data.delete();
        set_req(0, OP_RD, 817, 0);
        req[0] = 1'b1;
        wait_any(10, idx, cyc);
        chk("rd_idx", 32'(idx), 0);
        chk("rd_lat", 32'(cyc), 3);
        chk("rd_data", 32'(rsp_data), 4);
        chk("rd_ok", 32'(rsp_ok), 1);
        finish_txn();
        chk("rd_no_we", 32'(wq_addr.size()), 0);

        // Invalid: out-of-range write, then reserved op
        set_req(4, OP_WR, 1200, 9);
        req[4] = 1'b1;
        wait_any(10, idx, cyc);
        chk("oor_idx", 32'(idx), 4);
        chk("oor_lat", 32'(cyc), 1);
        chk("oor_ok", 32'(rsp_ok), 0);
        chk("oor_data", 32'(rsp_data), 0);
        finish_txn();
        set_req(4, OP_RSV, 5, 3);
        req[4] = 1'b1;
        wait_any(10, idx, cyc);
        chk("rsv_idx", 32'(idx), 4);
        chk("rsv_lat", 32'(cyc), 1);
        chk("rsv_ok", 32'(rsp_ok), 0);
        chk("rsv_data", 32'(rsp_data), 0);
        finish_txn();
        chk("inv_no_we", 32'(wq_addr.size()), 0);

        // Write-if-free onto a wall, then onto a free tile
        set_req(2, OP_WIF, 300, 5);
        req[2] = 1'b1;
        wait_any(10, idx, cyc);
        chk("wifw_idx", 32'(idx), 2);
        chk("wifw_lat", 32'(cyc), 3);
        chk("wifw_ok", 32'(rsp_ok), 0);
        chk("wifw_data", 32'(rsp_data), 1);
        finish_txn();
        chk("wifw_no_we", 32'(wq_addr.size()), 0);
        set_req(2, OP_WIF, 301, 7);
        req[2] = 1'b1;
        wait_any(10, idx, cyc);
        chk("wiff_idx", 32'(idx), 2);
        chk("wiff_lat", 32'(cyc), 4);
        chk("wiff_ok", 32'(rsp_ok), 1);
        chk("wiff_data", 32'(rsp_data), 2);
        finish_txn();
        chk("wiff_we_cnt", 32'(wq_addr.size()), 1);
        if (wq_addr.size() == 1) begin
            chk("wiff_we_addr", 32'(wq_addr[0]), 301);
            chk("wiff_we_data", 32'(wq_data[0]), 7);
        end
        chk("wiff_mem", 32'(mem[301]), 7);

        // Hold blocks arbitration
        hold = 1'b1;
        set_req(1, OP_RD, 817, 0);
        req[1] = 1'b1;
        nack = 0; nbusy = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack != 5'd0) nack++;
            if (busy) nbusy++;
        end
        chk("hold_ack", 32'(nack), 0);
        chk("hold_busy", 32'(nbusy), 0);

        // Release hold, then reset during WAIT
        hold = 1'b0;
        repeat (2) @(negedge clk);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_addr", 32'(mem_addr), 817);
        reset = 1'b1;
        chk("rstc_ack", 32'(ack), 0);
        chk("rstc_we", 32'(mem_we), 0);
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        chk("midrst_ack", 32'(ack), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rsp_data", 32'(rsp_data), 0);
        chk("midrst_rsp_ok", 32'(rsp_ok), 0);
        chk("midrst_mem_addr", 32'(mem_addr), 0);
        chk("midrst_mem_wdata", 32'(mem_wdata), 0);
        chk("midrst_mem_we", 32'(mem_we), 0);
        @(negedge clk);
        chk("midrst_no_ack", 32'(ack), 0);

        // Pointer restarts at 0: req[0] beats req[3]
        set_req(0, OP_RD, 817, 0);
        set_req(3, OP_RD, 301, 0);
        req = 5'b01001;
        wait_any(10, idx, cyc);
        chk("ptr0_idx", 32'(idx), 0);
        chk("ptr0_lat", 32'(cyc), 3);
        finish_txn();

        // Simultaneous writes: round-robin order, 3-cycle ack spacing
        do_reset();
        wq_addr.delete(); wq_data.delete();
        for (int i = 0; i < 5; i++) set_req(i, OP_WR, 100 + i, 8 + i);
        req = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            wait_any(10, idx, cyc);
            chk("sim_order", 32'(idx), 32'(k));
            chk("sim_spacing", 32'(cyc), (k == 0) ? 32'd2 : 32'd3);
            chk("sim_ok", 32'(rsp_ok), 1);
            chk("sim_data", 32'(rsp_data), 0);
            if (idx >= 0) req[idx] = 1'b0;
        end
        finish_txn();
        chk("sim_we_cnt", 32'(wq_addr.size()), 5);
        for (int i = 0; i < 5 && i < wq_addr.size(); i++) begin
            chk("sim_we_addr", 32'(wq_addr[i]), 32'(100 + i));
            chk("sim_we_data", 32'(wq_data[i]), 32'(8 + i));
        end

        // Fairness: req[3] held continuously, req[1] arrives after req[3]'s first grant
        do_reset();
        set_req(3, OP_RD, 817, 0);
        set_req(1, OP_RD, 300, 0);
        req[3] = 1'b1;
        wait_any(10, idx, cyc);
        chk("fair_first", 32'(idx), 3);
        chk("fair_first_lat", 32'(cyc), 3);
        req[1] = 1'b1;
        wait_any(10, idx, cyc);
        chk("fair_second", 32'(idx), 1);
        chk("fair_second_lat", 32'(cyc), 4);
        chk("fair_second_data", 32'(rsp_data), 1);
        req[1] = 1'b0;
        wait_any(10, idx, cyc);
        chk("fair_third", 32'(idx), 3);
        chk("fair_third_data", 32'(rsp_data), 4);
        finish_txn();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
